// File: rtl/wb_pkg.sv
// Shared types and constants for the two-lane writeback arbiter.
package wb_pkg;
  localparam int XLEN     = 32;
  localparam int RDW      = 5;
  localparam int LANES    = 2;
  localparam int LANE_ALU = 0;
  localparam int LANE_LSU = 1;

  typedef struct packed {
    logic [RDW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-lane result FIFO; full/empty come from registered pointers only, so ready never
// depends combinationally on the pop.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  wb_entry_t   mem_d [DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_entry;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU result lanes onto the single RF write port with round-robin
// arbitration, and tracks pending writes in a busy scoreboard for decode.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            lane0_valid,
  output logic            lane0_ready,
  input  logic [4:0]      lane0_rd,
  input  logic [XLEN-1:0] lane0_data,
  input  logic            lane1_valid,
  output logic            lane1_ready,
  input  logic [4:0]      lane1_rd,
  input  logic [XLEN-1:0] lane1_data,
  output logic            rf_writeEnable,
  output logic [4:0]      rf_dest,
  output logic [XLEN-1:0] rf_writeData,
  output logic [NREG-1:0] busy
);
  wb_entry_t              lane_in   [LANES];
  wb_entry_t              lane_head [LANES];
  logic [LANES-1:0]       lane_valid, lane_full, lane_empty, lane_pop;

  assign lane_in[LANE_ALU] = '{rd: lane0_rd, data: lane0_data};
  assign lane_in[LANE_LSU] = '{rd: lane1_rd, data: lane1_data};
  assign lane_valid        = {lane1_valid, lane0_valid};
  assign lane0_ready       = !lane_full[LANE_ALU];
  assign lane1_ready       = !lane_full[LANE_LSU];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lane_valid[g]),
      .push_entry(lane_in[g]),
      .pop       (lane_pop[g]),
      .full      (lane_full[g]),
      .empty     (lane_empty[g]),
      .head      (lane_head[g])
    );
  end

  logic            rr_q, rr_d;
  logic            we_q, we_d;
  logic [4:0]      dest_q, dest_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            gnt_vld, contended, gnt_lane;
  wb_entry_t       sel;

  // rr_q names the lane that wins the next contended cycle.
  always_comb begin
    contended = !lane_empty[0] && !lane_empty[1];
    gnt_vld   = !lane_empty[0] || !lane_empty[1];
    gnt_lane  = contended ? rr_q : lane_empty[0];
    rr_d      = contended ? !gnt_lane : rr_q;
    lane_pop  = '0;
    if (gnt_vld) lane_pop[gnt_lane] = 1'b1;
    sel       = lane_head[gnt_lane];

    we_d   = 1'b0;
    dest_d = dest_q;
    data_d = data_q;
    if (gnt_vld) begin
      we_d   = (sel.rd != '0);
      dest_d = sel.rd;
      data_d = sel.data;
    end
  end

  // Clear on commit first, then set, so a same-edge reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (we_q && int'(dest_q) == r) busy_d[r] = 1'b0;
      if (issue_valid && int'(issue_rd) == r) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rf_writeEnable = we_q;
  assign rf_dest        = dest_q;
  assign rf_writeData   = data_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: per-cycle vector table plus reset, backpressure sequences.
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        lane0_valid = 1'b0, lane1_valid = 1'b0;
  logic        lane0_ready, lane1_ready;
  logic [4:0]  lane0_rd = '0, lane1_rd = '0;
  logic [31:0] lane0_data = '0, lane1_data = '0;
  logic        rf_writeEnable;
  logic [4:0]  rf_dest;
  logic [31:0] rf_writeData;
  logic [31:0] busy;

  writeback_arbiter #(.DEPTH(2), .XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .lane0_valid(lane0_valid), .lane0_ready(lane0_ready), .lane0_rd(lane0_rd), .lane0_data(lane0_data),
    .lane1_valid(lane1_valid), .lane1_ready(lane1_ready), .lane1_rd(lane1_rd), .lane1_data(lane1_data),
    .rf_writeEnable(rf_writeEnable), .rf_dest(rf_dest), .rf_writeData(rf_writeData), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        v0;  logic [4:0] rd0; logic [31:0] d0;
    logic        v1;  logic [4:0] rd1; logic [31:0] d1;
    logic        we;  logic [4:0] dest; logic [31:0] data; logic [31:0] busy;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic v0, logic [4:0] rd0, logic [31:0] d0,
                              logic v1, logic [4:0] rd1, logic [31:0] d1,
                              logic we, logic [4:0] dest, logic [31:0] data, logic [31:0] bz);
    vec_t v;
    v.iv = iv; v.ird = ird; v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.we = we; v.dest = dest; v.data = data; v.busy = bz;
    return v;
  endfunction

  // Decode must never reissue to a busy rd unless that write commits at the same edge.
  task automatic drive_and_edge(input vec_t v);
    @(negedge clk);
    issue_valid = v.iv; issue_rd = v.ird;
    lane0_valid = v.v0; lane0_rd = v.rd0; lane0_data = v.d0;
    lane1_valid = v.v1; lane1_rd = v.rd1; lane1_data = v.d1;
    #1;
    if (issue_valid && issue_rd != 0 && busy[issue_rd] && !(rf_writeEnable && rf_dest == issue_rd))
      $error("illegal issue to busy rd %0d", issue_rd);
    @(posedge clk); #1;
  endtask

  vec_t idle_v;
  vec_t tbl [25];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [36:0] q0[$], q1[$];
    logic [36:0] expe;
    int sent0, sent1, got, gaps, cyc;
    logic started, saw_nr, r0, r1;

    idle_v = mk(0,0, 0,0,0, 0,0,0, 0,0,0,0);
    tbl[0]  = mk(1,5, 0,0,0,            0,0,0,            0,5'd0,32'h0,        32'h1<<5);
    tbl[1]  = mk(0,0, 1,5,32'hDEADBEEF, 0,0,0,            0,5'd0,32'h0,        32'h1<<5);
    tbl[2]  = mk(0,0, 0,0,0,            0,0,0,            1,5'd5,32'hDEADBEEF, 32'h1<<5);
    tbl[3]  = mk(0,0, 0,0,0,            0,0,0,            0,5'd5,32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(0,0, 1,3,32'h11,       1,7,32'h22,       0,5'd5,32'hDEADBEEF, 32'h0);
    tbl[5]  = mk(0,0, 0,0,0,            0,0,0,            1,5'd3,32'h11,       32'h0);
    tbl[6]  = mk(0,0, 0,0,0,            0,0,0,            1,5'd7,32'h22,       32'h0);
    tbl[7]  = mk(0,0, 0,0,0,            0,0,0,            0,5'd7,32'h22,       32'h0);
    tbl[8]  = mk(0,0, 1,4,32'h44,       1,8,32'h88,       0,5'd7,32'h22,       32'h0);
    tbl[9]  = mk(0,0, 0,0,0,            0,0,0,            1,5'd8,32'h88,       32'h0);
    tbl[10] = mk(0,0, 0,0,0,            0,0,0,            1,5'd4,32'h44,       32'h0);
    tbl[11] = mk(0,0, 0,0,0,            0,0,0,            0,5'd4,32'h44,       32'h0);
    tbl[12] = mk(1,6, 0,0,0,            1,0,32'hFFFFFFFF, 0,5'd4,32'h44,       32'h1<<6);
    tbl[13] = mk(0,0, 0,0,0,            0,0,0,            0,5'd0,32'hFFFFFFFF, 32'h1<<6);
    tbl[14] = mk(0,0, 0,0,0,            0,0,0,            0,5'd0,32'hFFFFFFFF, 32'h1<<6);
    tbl[15] = mk(0,0, 1,6,32'h66,       0,0,0,            0,5'd0,32'hFFFFFFFF, 32'h1<<6);
    tbl[16] = mk(0,0, 0,0,0,            0,0,0,            1,5'd6,32'h66,       32'h1<<6);
    tbl[17] = mk(0,0, 0,0,0,            0,0,0,            0,5'd6,32'h66,       32'h0);
    tbl[18] = mk(1,9, 0,0,0,            0,0,0,            0,5'd6,32'h66,       32'h1<<9);
    tbl[19] = mk(0,0, 1,9,32'h99,       0,0,0,            0,5'd6,32'h66,       32'h1<<9);
    tbl[20] = mk(0,0, 0,0,0,            0,0,0,            1,5'd9,32'h99,       32'h1<<9);
    tbl[21] = mk(1,9, 0,0,0,            0,0,0,            0,5'd9,32'h99,       32'h1<<9);
    tbl[22] = mk(0,0, 1,9,32'hAA,       0,0,0,            0,5'd9,32'h99,       32'h1<<9);
    tbl[23] = mk(0,0, 0,0,0,            0,0,0,            1,5'd9,32'hAA,       32'h1<<9);
    tbl[24] = mk(0,0, 0,0,0,            0,0,0,            0,5'd9,32'hAA,       32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_writeEnable, 0);
    chk("rst_dest", rf_dest, 0);
    chk("rst_data", rf_writeData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {lane1_ready, lane0_ready}, 2'b11);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive_and_edge(tbl[i]);
      chk($sformatf("v%0d_we", i),    rf_writeEnable, tbl[i].we);
      chk($sformatf("v%0d_dest", i),  rf_dest, tbl[i].dest);
      chk($sformatf("v%0d_data", i),  rf_writeData, tbl[i].data);
      chk($sformatf("v%0d_busy", i),  busy, tbl[i].busy);
      chk($sformatf("v%0d_ready", i), {lane1_ready, lane0_ready}, 2'b11);
    end

    // Backpressure: both lanes offer every cycle; check order, no loss, no bubbles.
    sent0 = 0; sent1 = 0; got = 0; gaps = 0; cyc = 0; started = 0; saw_nr = 0;
    while (got < 16 && cyc < 200) begin
      @(negedge clk);
      issue_valid = 1'b0;
      lane0_valid = (sent0 < 8); lane0_rd = 5'(1 + sent0);  lane0_data = 32'hA000_0000 | sent0;
      lane1_valid = (sent1 < 8); lane1_rd = 5'(16 + sent1); lane1_data = 32'hB000_0000 | sent1;
      r0 = lane0_ready; r1 = lane1_ready;
      if (!r0 || !r1) saw_nr = 1'b1;
      @(posedge clk); #1;
      if (lane0_valid && r0) begin q0.push_back({lane0_rd, lane0_data}); sent0++; end
      if (lane1_valid && r1) begin q1.push_back({lane1_rd, lane1_data}); sent1++; end
      if (rf_writeEnable) begin
        started = 1'b1;
        if (rf_writeData[31:28] == 4'hB) begin
          if (q1.size() == 0) expe = '0; else expe = q1.pop_front();
        end else begin
          if (q0.size() == 0) expe = '0; else expe = q0.pop_front();
        end
        chk($sformatf("bp_entry%0d", got), {rf_dest, rf_writeData}, expe);
        got++;
      end else if (started) gaps++;
      cyc++;
    end
    lane0_valid = 1'b0; lane1_valid = 1'b0;
    chk("bp_count", got, 16);
    chk("bp_gaps", gaps, 0);
    chk("bp_ready_dropped", saw_nr, 1);
    chk("bp_leftover", q0.size() + q1.size(), 0);

    // Reset mid-stream with queued entries and a busy register.
    drive_and_edge(mk(1,12, 1,2,32'h1234, 1,3,32'h5678, 0,0,0,0));
    drive_and_edge(mk(0,0,  1,4,32'h4444, 1,5,32'h5555, 0,0,0,0));
    chk("pre_rst_we", rf_writeEnable, 1);
    chk("pre_rst_busy", busy, 32'h1 << 12);
    @(negedge clk);
    lane0_valid = 1'b0; lane1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", rf_writeEnable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", {lane1_ready, lane0_ready}, 2'b11);
    chk("mid_rst_dest", rf_dest, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_and_edge(idle_v);
      chk($sformatf("post_rst_we%0d", i), rf_writeEnable, 0);
    end
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
